// File: rtl/cpu6502_pkg.sv
// Shared 6502 CPU definitions: flag bit positions, status-register op encodings,
// branch-condition selects and the P byte packing helper.
package cpu6502_pkg;

  // Bit positions in the architectural P byte
  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_I = 2;
  localparam int unsigned FLAG_D = 3;
  localparam int unsigned FLAG_B = 4;
  localparam int unsigned FLAG_U = 5;
  localparam int unsigned FLAG_V = 6;
  localparam int unsigned FLAG_N = 7;

  // Bit positions in the 6-bit internal register {N,V,D,I,Z,C}
  localparam int unsigned PI_C = 0;
  localparam int unsigned PI_Z = 1;
  localparam int unsigned PI_I = 2;
  localparam int unsigned PI_D = 3;
  localparam int unsigned PI_V = 4;
  localparam int unsigned PI_N = 5;

  localparam logic [2:0] P_OP_NONE   = 3'd0;
  localparam logic [2:0] P_OP_ALU    = 3'd1;
  localparam logic [2:0] P_OP_SET    = 3'd2;
  localparam logic [2:0] P_OP_CLR    = 3'd3;
  localparam logic [2:0] P_OP_LOAD   = 3'd4;
  localparam logic [2:0] P_OP_IRQENT = 3'd5;
  localparam logic [2:0] P_OP_BIT    = 3'd6;

  localparam logic [1:0] BR_SEL_N = 2'd0;
  localparam logic [1:0] BR_SEL_V = 2'd1;
  localparam logic [1:0] BR_SEL_C = 2'd2;
  localparam logic [1:0] BR_SEL_Z = 2'd3;

  // Expand the internal register to a P byte; bit5 is always 1, bit4 is caller's B
  function automatic logic [7:0] p_expand(input logic [5:0] f, input logic b);
    return {f[PI_N], f[PI_V], 1'b1, b, f[PI_D], f[PI_I], f[PI_Z], f[PI_C]};
  endfunction

endpackage

// File: rtl/status_register_branch_eval.sv
// Combinational branch-condition evaluation: selected P flag compared against
// the polarity bit of br_cond.
module branch_eval
  import cpu6502_pkg::*;
(
  input  logic [7:0] p,
  input  logic [2:0] br_cond,
  output logic       branch_taken
);

  logic flag;
  logic unused_p;

  always_comb begin
    flag = p[FLAG_N];
    case (br_cond[2:1])
      BR_SEL_N: flag = p[FLAG_N];
      BR_SEL_V: flag = p[FLAG_V];
      BR_SEL_C: flag = p[FLAG_C];
      BR_SEL_Z: flag = p[FLAG_Z];
      default:  flag = p[FLAG_N];
    endcase
    branch_taken = (flag == br_cond[0]);
  end

  assign unused_p = ^p[5:2];

endmodule

// File: rtl/status_register.sv
// 6502 processor status register: ALU flag commit, flag instructions, PLP/RTI load,
// push image, branch evaluation and delayed I mask. Decimal storage under STATUS_DECIMAL_EN.
module status_register
  import cpu6502_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] flags_in,
  input  logic [7:0] flags_ena,
  input  logic [2:0] p_op,
  input  logic [2:0] bit_sel,
  input  logic [7:0] data_in,
  input  logic       push_brk,
  input  logic       instr_done,
  input  logic [2:0] br_cond,
  output logic [7:0] p_out,
  output logic [7:0] push_out,
  output logic       branch_taken,
  output logic       irq_mask
);

`ifdef STATUS_DECIMAL_EN
  localparam logic [5:0] WRITABLE = 6'b111111;
`else
  // D never written, so it stays at its reset value of 0
  localparam logic [5:0] WRITABLE = 6'b110111;
`endif
  localparam logic [5:0] RESET_FLAGS = 6'b000100;

  logic [5:0] flags_q, flags_d;
  logic       irq_mask_q, irq_mask_d;
  logic [5:0] fin6, fena6, din6, sel6;
  logic [5:0] new_val, wr_mask_raw, wr_mask;
  logic       unused_bits;

  assign fin6  = {flags_in[FLAG_N], flags_in[FLAG_V], flags_in[FLAG_D],
                  flags_in[FLAG_I], flags_in[FLAG_Z], flags_in[FLAG_C]};
  assign fena6 = {flags_ena[FLAG_N], flags_ena[FLAG_V], flags_ena[FLAG_D],
                  flags_ena[FLAG_I], flags_ena[FLAG_Z], flags_ena[FLAG_C]};
  assign din6  = {data_in[FLAG_N], data_in[FLAG_V], data_in[FLAG_D],
                  data_in[FLAG_I], data_in[FLAG_Z], data_in[FLAG_C]};
  assign unused_bits = ^{flags_in[5:4], flags_ena[5:4], data_in[5:4]};

  always_comb begin
    sel6 = '0;
    case (bit_sel)
      3'd0:    sel6[PI_C] = 1'b1;
      3'd1:    sel6[PI_Z] = 1'b1;
      3'd2:    sel6[PI_I] = 1'b1;
      3'd3:    sel6[PI_D] = 1'b1;
      3'd6:    sel6[PI_V] = 1'b1;
      3'd7:    sel6[PI_N] = 1'b1;
      default: sel6 = '0;
    endcase
  end

  // Each op supplies a candidate value and a write mask; masked merge below
  always_comb begin
    new_val     = flags_q;
    wr_mask_raw = '0;
    case (p_op)
      P_OP_ALU: begin
        new_val     = fin6;
        wr_mask_raw = fena6;
      end
      P_OP_SET: begin
        new_val     = '1;
        wr_mask_raw = sel6;
      end
      P_OP_CLR: begin
        new_val     = '0;
        wr_mask_raw = sel6;
      end
      P_OP_LOAD: begin
        new_val     = din6;
        wr_mask_raw = '1;
      end
      P_OP_IRQENT: begin
        new_val[PI_I]     = 1'b1;
        new_val[PI_D]     = 1'b0;
        wr_mask_raw[PI_I] = 1'b1;
        wr_mask_raw[PI_D] = 1'b1;
      end
      P_OP_BIT: begin
        new_val[PI_N]     = data_in[FLAG_N];
        new_val[PI_V]     = data_in[FLAG_V];
        new_val[PI_Z]     = flags_in[FLAG_Z];
        wr_mask_raw[PI_N] = 1'b1;
        wr_mask_raw[PI_V] = 1'b1;
        wr_mask_raw[PI_Z] = 1'b1;
      end
      default: begin
        new_val     = flags_q;
        wr_mask_raw = '0;
      end
    endcase
    wr_mask    = wr_mask_raw & WRITABLE;
    flags_d    = (flags_q & ~wr_mask) | (new_val & wr_mask);
    // Pre-update I gives CLI/SEI/PLP their one-instruction delay
    irq_mask_d = instr_done ? flags_q[PI_I] : irq_mask_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q    <= RESET_FLAGS;
      irq_mask_q <= 1'b1;
    end else begin
      flags_q    <= flags_d;
      irq_mask_q <= irq_mask_d;
    end
  end

  assign p_out    = p_expand(flags_q, 1'b1);
  assign push_out = p_expand(flags_q, push_brk);
  assign irq_mask = irq_mask_q;

  branch_eval u_branch_eval (
    .p            (p_out),
    .br_cond      (br_cond),
    .branch_taken (branch_taken)
  );

endmodule

// File: tb/tb_status_register.sv
// Self-checking bench for status_register: byte-level P model checked every
// cycle plus directed literal expectations. Honours STATUS_DECIMAL_EN.
module tb_status_register;
  import cpu6502_pkg::*;

`ifdef STATUS_DECIMAL_EN
  localparam bit DEC = 1'b1;
`else
  localparam bit DEC = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] op;
    logic [2:0] sel;
    logic [7:0] fin;
    logic [7:0] fena;
    logic [7:0] din;
    logic       done;
    logic [2:0] bc;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] flags_in, flags_ena, data_in;
  logic [2:0] p_op, bit_sel, br_cond;
  logic       push_brk, instr_done;
  logic [7:0] p_out, push_out;
  logic       branch_taken, irq_mask;

  int   checks = 0;
  int   errors = 0;
  logic [7:0] m_p;
  logic       m_irq;
  logic       chk_en = 1'b0;
  vec_t       tbl [12];

  always #5 clk = ~clk;

  status_register dut (
    .clk          (clk),
    .reset        (reset),
    .flags_in     (flags_in),
    .flags_ena    (flags_ena),
    .p_op         (p_op),
    .bit_sel      (bit_sel),
    .data_in      (data_in),
    .push_brk     (push_brk),
    .instr_done   (instr_done),
    .br_cond      (br_cond),
    .p_out        (p_out),
    .push_out     (push_out),
    .branch_taken (branch_taken),
    .irq_mask     (irq_mask)
  );

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, got, exp, $time);
    end
  endtask

  // Architectural P byte after one op; bits 5 and 4 of the model byte always read 1
  function automatic logic [7:0] model_next(input logic [7:0] p, input logic [2:0] op,
                                            input logic [2:0] sel, input logic [7:0] fin,
                                            input logic [7:0] fena, input logic [7:0] din);
    logic [7:0] r;
    r = p;
    case (op)
      3'd1: for (int k = 0; k < 8; k++)
              if (fena[k] && k != 4 && k != 5 && (k != 3 || DEC)) r[k] = fin[k];
      3'd2, 3'd3:
        if (sel != 3'd4 && sel != 3'd5 && (sel != 3'd3 || DEC)) r[sel] = (op == 3'd2);
      3'd4: begin
        r = din | 8'h30;
        if (!DEC) r[3] = 1'b0;
      end
      3'd5: begin
        r[2] = 1'b1;
        if (DEC) r[3] = 1'b0;
      end
      3'd6: begin
        r[7] = din[7];
        r[6] = din[6];
        r[1] = fin[1];
      end
      default: r = p;
    endcase
    return r;
  endfunction

  function automatic logic model_branch(input logic [7:0] p, input logic [2:0] bc);
    logic f;
    case (bc[2:1])
      2'd0:    f = p[7];
      2'd1:    f = p[6];
      2'd2:    f = p[0];
      default: f = p[1];
    endcase
    return f == bc[0];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check8("p_out", p_out, m_p);
      check8("push_out", push_out, (m_p & 8'hEF) | {3'b000, push_brk, 4'b0000});
      check8("branch_taken", {7'b0, branch_taken}, {7'b0, model_branch(m_p, br_cond)});
      check8("irq_mask", {7'b0, irq_mask}, {7'b0, m_irq});
    end
  end

  task automatic step(input logic [2:0] op, input logic [2:0] sel, input logic [7:0] fin,
                      input logic [7:0] fena, input logic [7:0] din, input logic done,
                      input logic [2:0] bc);
    logic [7:0] nxt;
    logic       nirq;
    @(negedge clk);
    #1;
    p_op = op; bit_sel = sel; flags_in = fin; flags_ena = fena;
    data_in = din; instr_done = done; br_cond = bc;
    nxt  = model_next(m_p, op, sel, fin, fena, din);
    nirq = done ? m_p[2] : m_irq;
    @(posedge clk);
    m_p   = nxt;
    m_irq = nirq;
    #1;
    p_op = P_OP_NONE; instr_done = 1'b0;
  endtask

  initial begin
    reset = 1'b1; p_op = P_OP_NONE; bit_sel = 3'd0; flags_in = 8'h00; flags_ena = 8'h00;
    data_in = 8'h00; push_brk = 1'b1; instr_done = 1'b0; br_cond = 3'b111;
    m_p = 8'h34; m_irq = 1'b1;
    #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check8("reset_p_out", p_out, 8'h34);
    check8("reset_irq_mask", {7'b0, irq_mask}, 8'h01);
    check8("reset_push_brk1", push_out, 8'h34);
    check8("reset_beq", {7'b0, branch_taken}, 8'h00);
    push_brk = 1'b0;
    #1 check8("reset_push_brk0", push_out, 8'h24);

    step(P_OP_ALU, 3'd0, 8'hC3, 8'h42, 8'h00, 1'b0, 3'b111);
    check8("alu_c3_42", p_out, 8'h76);
    check8("alu_c_hold", {7'b0, p_out[0]}, 8'h00);

    step(P_OP_SET, 3'd2, 8'h00, 8'h00, 8'h00, 1'b1, 3'b111);
    check8("sei_p", p_out, 8'h76);
    step(P_OP_CLR, 3'd2, 8'h00, 8'h00, 8'h00, 1'b1, 3'b111);
    check8("cli_p", p_out, 8'h72);
    check8("cli_irq_delay", {7'b0, irq_mask}, 8'h01);
    step(P_OP_NONE, 3'd0, 8'h00, 8'h00, 8'h00, 1'b1, 3'b111);
    check8("cli_irq_next", {7'b0, irq_mask}, 8'h00);

    step(P_OP_LOAD, 3'd0, 8'h00, 8'h00, 8'hFF, 1'b0, 3'b111);
    check8("load_ff", p_out, DEC ? 8'hFF : 8'hF7);
    check8("php_brk0", push_out, DEC ? 8'hEF : 8'hE7);

    step(P_OP_BIT, 3'd0, 8'h02, 8'h00, 8'h80, 1'b0, 3'b111);
    check8("bit_80", p_out, DEC ? 8'hBF : 8'hB7);
    check8("bit_beq", {7'b0, branch_taken}, 8'h01);

    step(P_OP_LOAD, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0, 3'b111);
    check8("load_00", p_out, 8'h30);
    step(P_OP_SET, 3'd3, 8'h00, 8'h00, 8'h00, 1'b0, 3'b111);
    check8("sed_d", {7'b0, p_out[3]}, DEC ? 8'h01 : 8'h00);
    step(P_OP_IRQENT, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0, 3'b111);
    check8("irqent", p_out, 8'h34);

    tbl = '{
      '{P_OP_ALU,    3'd0, 8'h55, 8'hFF, 8'h00, 1'b0, 3'b000},
      '{P_OP_SET,    3'd4, 8'h00, 8'h00, 8'h00, 1'b0, 3'b001},
      '{P_OP_CLR,    3'd5, 8'h00, 8'h00, 8'h00, 1'b1, 3'b010},
      '{3'd7,        3'd0, 8'hFF, 8'hFF, 8'hFF, 1'b0, 3'b011},
      '{P_OP_SET,    3'd7, 8'h00, 8'h00, 8'h00, 1'b0, 3'b100},
      '{P_OP_CLR,    3'd6, 8'h00, 8'h00, 8'h00, 1'b0, 3'b101},
      '{P_OP_ALU,    3'd0, 8'h08, 8'h08, 8'h00, 1'b0, 3'b110},
      '{P_OP_IRQENT, 3'd0, 8'h00, 8'h00, 8'h00, 1'b1, 3'b111},
      '{P_OP_CLR,    3'd2, 8'h00, 8'h00, 8'h00, 1'b1, 3'b000},
      '{P_OP_NONE,   3'd0, 8'h00, 8'h00, 8'h00, 1'b1, 3'b011},
      '{P_OP_LOAD,   3'd0, 8'h00, 8'h00, 8'h5A, 1'b0, 3'b010},
      '{P_OP_BIT,    3'd0, 8'h00, 8'h00, 8'h40, 1'b1, 3'b101}
    };
    for (int i = 0; i < 12; i++)
      step(tbl[i].op, tbl[i].sel, tbl[i].fin, tbl[i].fena, tbl[i].din, tbl[i].done, tbl[i].bc);

    // Asynchronous reset in the middle of an ALU op
    @(negedge clk);
    #1;
    p_op = P_OP_ALU; flags_in = 8'hFF; flags_ena = 8'hFF; instr_done = 1'b1;
    #2;
    reset = 1'b1; m_p = 8'h34; m_irq = 1'b1;
    #1;
    check8("midop_reset_p", p_out, 8'h34);
    check8("midop_reset_irq", {7'b0, irq_mask}, 8'h01);
    @(posedge clk);
    #1;
    p_op = P_OP_NONE; instr_done = 1'b0;
    @(negedge clk);
    #1 reset = 1'b0;
    step(P_OP_NONE, 3'd0, 8'h00, 8'h00, 8'h00, 1'b1, 3'b111);
    check8("post_reset_p", p_out, 8'h34);

    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
